// File: rtl/dm_pkg.sv
// Shared types for the debug-module bus arbiter: FSM states, requester ids,
// bus geometry and the registered command word.
package dm_pkg;
   localparam int DM_AW = 18;
   localparam int DM_DW = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } dm_state_e;

   typedef enum logic {
      REQ_FETCH = 1'b0,
      REQ_LSU   = 1'b1
   } dm_req_id_e;

   typedef struct packed {
      logic             write;
      logic [DM_AW-1:0] addr;
      logic [DM_DW-1:0] wdata;
   } dm_cmd_t;
endpackage

// File: rtl/dm_bus_arb_if.sv
// Requester-side and dm-side handshake bundles. master drives the request,
// slave returns ready/data.
interface dm_req_if;
   import dm_pkg::*;
   logic             valid;
   logic             ready;
   logic             write;
   logic [DM_AW-1:0] addr;
   logic [DM_DW-1:0] wdata;
   logic [DM_DW-1:0] rdata;
   logic             err;

   modport master (output valid, write, addr, wdata, input ready, rdata, err);
   modport slave  (input valid, write, addr, wdata, output ready, rdata, err);
endinterface

interface dm_mem_if;
   import dm_pkg::*;
   logic             valid;
   logic             ready;
   logic             write;
   logic [DM_AW-1:0] addr;
   logic [DM_DW-1:0] wdata;
   logic [DM_DW-1:0] rdata;

   modport master (output valid, write, addr, wdata, input ready, rdata);
   modport slave  (input valid, write, addr, wdata, output ready, rdata);
endinterface

// File: rtl/dm_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that did
// not win last time is chosen; a lone requester always wins.
module dm_rr_pick2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic       gnt,
   output logic       any
);
   assign any = |valid;
   assign gnt = valid[1] & ~(valid[0] & last);
endmodule

// File: rtl/dm_bus_arb.sv
// Round-robin arbiter between core fetch (m0) and load/store (m1) for the
// debug-module bus; one transaction in flight, registered bus side, watchdog abort.
module dm_bus_arb
   import dm_pkg::*;
#(
   parameter int TO_CYCLES = 15,
   parameter int TO_W      = 4
) (
   input logic      clk,
   input logic      resetn,
   dm_req_if.slave  m0,
   dm_req_if.slave  m1,
   dm_mem_if.master bus
);
   dm_state_e             state_q, state_d;
   dm_req_id_e            gnt_q, last_q;
   logic                  pick_gnt, pick_any;
   dm_cmd_t               cmd_q, cmd_in;
   logic                  bv_q;
   logic [TO_W-1:0]       wdog_q;
   logic [1:0]            rdy_q, err_q;
   logic [1:0][DM_DW-1:0] rdata_q;
   logic                  hs, to_hit;

   dm_rr_pick2 u_pick (
      .valid ({m1.valid, m0.valid}),
      .last  (last_q),
      .gnt   (pick_gnt),
      .any   (pick_any)
   );

   always_comb begin
      cmd_in = '{write: m0.write, addr: m0.addr, wdata: m0.wdata};
      if (pick_gnt) cmd_in = '{write: m1.write, addr: m1.addr, wdata: m1.wdata};
   end

   // bv_q is only ever high in REQ, so hs needs no state qualifier
   assign hs     = bv_q & bus.ready;
   assign to_hit = (TO_CYCLES != 0) && (wdog_q == TO_W'(TO_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_any) state_d = REQ;
         REQ:     if (hs || to_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         gnt_q   <= REQ_FETCH;
         last_q  <= REQ_LSU;
         cmd_q   <= '0;
         bv_q    <= 1'b0;
         wdog_q  <= '0;
         rdy_q   <= '0;
         err_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= '0;
         err_q   <= '0;
         case (state_q)
            IDLE: if (pick_any) begin
               gnt_q  <= dm_req_id_e'(pick_gnt);
               last_q <= dm_req_id_e'(pick_gnt);
               cmd_q  <= cmd_in;
               bv_q   <= 1'b1;
               wdog_q <= '0;
            end
            REQ: begin
               // a real acceptance beats a simultaneous watchdog expiry
               if (hs) begin
                  bv_q           <= 1'b0;
                  rdy_q[gnt_q]   <= 1'b1;
                  rdata_q[gnt_q] <= cmd_q.write ? '0 : bus.rdata;
               end else if (to_hit) begin
                  bv_q           <= 1'b0;
                  rdy_q[gnt_q]   <= 1'b1;
                  err_q[gnt_q]   <= 1'b1;
                  rdata_q[gnt_q] <= '0;
               end else if (wdog_q != TO_W'(TO_CYCLES)) begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.valid = bv_q;
   assign bus.write = cmd_q.write;
   assign bus.addr  = cmd_q.addr;
   assign bus.wdata = cmd_q.wdata;

   assign m0.ready  = rdy_q[0];
   assign m0.err    = err_q[0];
   assign m0.rdata  = rdata_q[0];
   assign m1.ready  = rdy_q[1];
   assign m1.err    = err_q[1];
   assign m1.rdata  = rdata_q[1];
endmodule
